// File: rtl/restoring_divider_8bit_pkg.sv
// Shared definitions for the restoring divider: FSM states, the default width
// and the iteration counter width.
package restoring_divider_8bit_pkg;

  localparam int DIV_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // A 1-bit counter is still needed for the degenerate WIDTH=1 case.
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W = cnt_w(DIV_WIDTH);

endpackage

// File: rtl/restoring_divider_8bit_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor and restore on borrow.
module restoring_divider_8bit_div_step
  import restoring_divider_8bit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   p_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   p_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+2:0] diff;
  logic             borrow;

  // p_in stays below the divisor, so its top bit is always 0 and the wide
  // shift matches {P[WIDTH-1:0], bit} exactly.
  always_comb begin
    shifted = {p_in, bit_in};
    diff    = {1'b0, shifted} - {3'b000, divisor};
    borrow  = diff[WIDTH+2];
    q_bit   = ~borrow;
    p_out   = borrow ? shifted[WIDTH:0] : diff[WIDTH:0];
  end

endmodule

// File: rtl/restoring_divider_8bit.sv
// Sequential unsigned divider, one quotient bit per clock, with valid/ready
// handshakes on both the operand and the result side.
module restoring_divider_8bit
  import restoring_divider_8bit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid-side data is held stable until that edge.
  localparam int CW = cnt_w(WIDTH);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;

  logic [WIDTH:0]   step_p;
  logic             step_bit;

  restoring_divider_8bit_div_step #(.WIDTH(WIDTH)) u_step (
    .p_in    (p_q),
    .bit_in  (q_q[WIDTH-1]),
    .divisor (dvs_q),
    .p_out   (step_p),
    .q_bit   (step_bit)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    p_d         = p_q;
    q_d         = q_q;
    dvs_d       = dvs_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    dbz_d       = dbz_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          busy_d = 1'b1;
          if (divisor != '0) begin
            state_d = RUN;
            cnt_d   = CW'(WIDTH - 1);
            p_d     = '0;
            q_d     = dividend;
            dvs_d   = divisor;
          end else begin
            state_d     = DONE;
            quot_d      = '1;
            rem_d       = dividend;
            dbz_d       = 1'b1;
            out_valid_d = 1'b1;
          end
        end
      end
      RUN: begin
        p_d = step_p;
        q_d = {q_q[WIDTH-2:0], step_bit};
        if (cnt_q == '0) begin
          state_d     = DONE;
          quot_d      = {q_q[WIDTH-2:0], step_bit};
          rem_d       = step_p[WIDTH-1:0];
          dbz_d       = 1'b0;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          dbz_d       = 1'b0;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        dbz_d       = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      p_q         <= '0;
      q_q         <= '0;
      dvs_q       <= '0;
      quot_q      <= '0;
      rem_q       <= '0;
      dbz_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      p_q         <= p_d;
      q_q         <= q_d;
      dvs_q       <= dvs_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      dbz_q       <= dbz_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign busy        = busy_q;

endmodule

// File: doc/restoring_divider_8bit.md
Name: restoring_divider_8bit

Overview:
Sequential unsigned integer divider for the arithmetic datapath. It complements the 8-bit multiplier by computing quotient and remainder from a dividend and divisor. It uses a restoring shift/subtract algorithm, one quotient bit per clock. Operands enter and results leave through valid/ready handshakes, so the block can sit between a producer and a consumer that stalls.

Parameters:
WIDTH, 8, operand width in bits for dividend, divisor, quotient and remainder.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  dividend/divisor are valid this cycle.
- in_ready  output  1  block can accept operands this cycle.
- dividend  input  WIDTH  unsigned dividend.
- divisor  input  WIDTH  unsigned divisor.
- out_valid  output  1  quotient/remainder/div_by_zero are valid.
- out_ready  input  1  consumer accepts the result this cycle.
- quotient  output  WIDTH  unsigned quotient.
- remainder  output  WIDTH  unsigned remainder.
- div_by_zero  output  1  the current result came from a divisor of 0.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; in_ready=0 while asserted; out_valid=0, quotient=0, remainder=0, div_by_zero=0, busy=0; iteration counter=0. Reset mid-RUN or mid-DONE aborts the operation and drops the result, with no output pulse.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch the operands.
    - divisor!=0 -> RUN, counter=WIDTH-1, partial remainder P (WIDTH+1 bits)=0, shift register Q=dividend.
    - divisor==0 -> DONE directly; quotient={WIDTH{1}}, remainder=dividend, div_by_zero=1.
  - RUN: each cycle form T={P[WIDTH-1:0],Q[WIDTH-1]} minus {1'b0,divisor}.
    - If no borrow: P=T, shift 1 into Q LSB.
    - Else: P={P[WIDTH-1:0],Q[WIDTH-1]} (restore), shift 0 into Q LSB.
    - Counter decrements; on the step with counter==0 -> DONE.
  - DONE: out_valid=1. quotient=Q and remainder=P[WIDTH-1:0] (or the div-by-zero values). Outputs are held stable while out_ready=0. On out_ready=1 -> IDLE; out_valid and div_by_zero clear next cycle. quotient/remainder keep their last values (don't-care when out_valid=0).
- in_ready is 0 in RUN and DONE. There is no bypass: a new operand pair is accepted at the earliest in the cycle after the result handshake.
- Latency from the accept edge to the first out_valid cycle:
  - Normal division: WIDTH+1 cycles, i.e. 9 for WIDTH=8.
  - Divide by zero: 1 cycle.
- Throughput: one division per WIDTH+2 cycles with out_ready held at 1.
- in_valid while not in_ready is ignored and nothing is latched. Operands may change freely after the accept cycle.
- Invariant on a normal result: dividend == quotient*divisor + remainder, and remainder < divisor.
- No X on outputs after reset. Combinational paths from in_valid/out_ready to outputs are forbidden; all outputs are registered or state-decoded.

Decomposition:
- Shared arith package holds:
  - state enum {IDLE, RUN, DONE} (2-bit encoding);
  - default WIDTH constant;
  - a helper constant for the counter width, $clog2(WIDTH).
- One natural combinational sub-module, div_step: inputs P, next dividend bit and divisor; outputs new P and the quotient bit. It keeps the subtract/restore logic isolated and unit-testable.
- FSM, counter and handshake logic stay in the top.

Test Plan:
- Accept 200/7, out_ready=1 -> out_valid exactly 9 cycles after accept; quotient=28, remainder=4, div_by_zero=0.
- Accept 255/1, then 5/9, then 0/3 back-to-back -> (255,0), (5 div 9 = 0, rem 5), (0,0) in order; in_ready low throughout RUN and DONE.
- Accept 100/0 -> out_valid next cycle; quotient=255, remainder=100, div_by_zero=1; a following 100/10 gives (10,0) with div_by_zero=0.
- Accept 250/16 with out_ready=0 for 5 cycles after out_valid -> quotient=15, remainder=10 held stable; in_ready=0; result consumed on the first out_ready=1 cycle, then IDLE.
- Pull rst_n low 4 cycles into a 77/3 RUN -> all outputs 0 immediately (async); no out_valid; after release, 77/3 gives (25,2).
- Random sweep of 10k operand pairs, divisor!=0 -> invariant holds against a reference model; latency is always 9.
